// File: rtl/udp_oe_pkg.sv
// rtl/udp_oe_pkg.sv - shared types and constants for the UDP offload engine TX path
package udp_oe_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ARP  = 2'd1,
      ARB_UDP  = 2'd2
   } arb_state_t;

   localparam int MAX_ARP_BURST_DEFAULT = 2;

   // Saturating increment used by the ARP burst limiter.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

// File: rtl/udp_oe_axis_outreg.sv
// rtl/udp_oe_axis_outreg.sv - single-stage registered stream output with ready pass-back
module udp_oe_axis_outreg #(
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_W-1:0]     s_tdata,
   input  logic [DATA_W/8-1:0]   s_tkeep,
   input  logic                  s_tlast,
   output logic                  m_tvalid,
   output logic [DATA_W-1:0]     m_tdata,
   output logic [DATA_W/8-1:0]   m_tkeep,
   output logic                  m_tlast,
   input  logic                  m_tready
);

   // Space exists when the register is empty or is being drained this cycle.
   assign s_tready = !m_tvalid || m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tlast  <= 1'b0;
      end else if (s_tvalid && s_tready) begin
         m_tvalid <= 1'b1;
         m_tdata  <= s_tdata;
         m_tkeep  <= s_tkeep;
         m_tlast  <= s_tlast;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/udp_oe_tx_arb.sv
// rtl/udp_oe_tx_arb.sv - packet-atomic 2:1 ARP/UDP arbiter in front of the MAC TX stream
module udp_oe_tx_arb
   import udp_oe_pkg::*;
#(
   parameter int DATA_W        = 64,
   parameter int MAX_ARP_BURST = MAX_ARP_BURST_DEFAULT,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_enable,
   input  logic                  arp_tvalid,
   output logic                  arp_tready,
   input  logic                  arp_tlast,
   input  logic [DATA_W-1:0]     arp_tdata,
   input  logic [DATA_W/8-1:0]   arp_tkeep,
   input  logic                  udp_tvalid,
   output logic                  udp_tready,
   input  logic                  udp_tlast,
   input  logic [DATA_W-1:0]     udp_tdata,
   input  logic [DATA_W/8-1:0]   udp_tkeep,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   output logic [DATA_W-1:0]     m_tdata,
   output logic [DATA_W/8-1:0]   m_tkeep,
   input  logic                  m_tready,
   output logic [1:0]            arb_state,
   output logic [CNT_W-1:0]      arp_frame_cnt,
   output logic [CNT_W-1:0]      udp_frame_cnt
);

   localparam int               KEEP_W    = DATA_W / 8;
   localparam logic [3:0]       BURST_LIM = 4'(MAX_ARP_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   arb_state_t          state;
   logic [3:0]          arp_streak;
   logic                out_ready;
   logic                arp_acc;
   logic                udp_acc;
   logic                ld_valid;
   logic                ld_last;
   logic [DATA_W-1:0]   ld_data;
   logic [KEEP_W-1:0]   ld_keep;

   // Only the granted source sees ready; it follows the output stage directly.
   assign arp_tready = (state == ARB_ARP) && out_ready;
   assign udp_tready = (state == ARB_UDP) && out_ready;
   assign arp_acc    = arp_tvalid && arp_tready;
   assign udp_acc    = udp_tvalid && udp_tready;
   assign arb_state  = state;

   always_comb begin
      ld_valid = arp_acc || udp_acc;
      ld_data  = arp_tdata;
      ld_keep  = arp_tkeep;
      ld_last  = arp_tlast;
      if (state == ARB_UDP) begin
         ld_data = udp_tdata;
         ld_keep = udp_tkeep;
         ld_last = udp_tlast;
      end
   end

   udp_oe_axis_outreg #(
      .DATA_W (DATA_W)
   ) u_outreg (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (ld_valid),
      .s_tready (out_ready),
      .s_tdata  (ld_data),
      .s_tkeep  (ld_keep),
      .s_tlast  (ld_last),
      .m_tvalid (m_tvalid),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tlast  (m_tlast),
      .m_tready (m_tready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB_IDLE;
         arp_streak    <= 4'd0;
         arp_frame_cnt <= '0;
         udp_frame_cnt <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (tx_enable && (arp_tvalid || udp_tvalid)) begin
                  // ARP wins unless UDP has waited through a full ARP burst.
                  if (arp_tvalid && (!udp_tvalid || arp_streak < BURST_LIM)) begin
                     state <= ARB_ARP;
                     if (udp_tvalid)
                        arp_streak <= sat_inc4(arp_streak, BURST_LIM);
                  end else begin
                     state      <= ARB_UDP;
                     arp_streak <= 4'd0;
                  end
               end
            end
            ARB_ARP: begin
               if (arp_acc && arp_tlast) begin
                  state         <= ARB_IDLE;
                  arp_frame_cnt <= arp_frame_cnt + CNT_ONE;
               end
            end
            ARB_UDP: begin
               if (udp_acc && udp_tlast) begin
                  state         <= ARB_IDLE;
                  udp_frame_cnt <= udp_frame_cnt + CNT_ONE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_oe_tx_arb.sv
// tb/tb_udp_oe_tx_arb.sv - self-checking bench for udp_oe_tx_arb against a behavioural model
module tb_udp_oe_tx_arb;

   localparam int DATA_W = 64;
   localparam int KEEP_W = 8;
   localparam int CNT_W  = 4;
   localparam int BURST  = 2;
   localparam int CNT_M  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, tx_enable;
   logic              arp_tvalid, arp_tready, arp_tlast;
   logic [DATA_W-1:0] arp_tdata;
   logic [KEEP_W-1:0] arp_tkeep;
   logic              udp_tvalid, udp_tready, udp_tlast;
   logic [DATA_W-1:0] udp_tdata;
   logic [KEEP_W-1:0] udp_tkeep;
   logic              m_tvalid, m_tlast, m_tready;
   logic [DATA_W-1:0] m_tdata;
   logic [KEEP_W-1:0] m_tkeep;
   logic [1:0]        arb_state;
   logic [CNT_W-1:0]  arp_frame_cnt, udp_frame_cnt;

   udp_oe_tx_arb #(
      .DATA_W        (DATA_W),
      .MAX_ARP_BURST (BURST),
      .CNT_W         (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_enable     (tx_enable),
      .arp_tvalid    (arp_tvalid),
      .arp_tready    (arp_tready),
      .arp_tlast     (arp_tlast),
      .arp_tdata     (arp_tdata),
      .arp_tkeep     (arp_tkeep),
      .udp_tvalid    (udp_tvalid),
      .udp_tready    (udp_tready),
      .udp_tlast     (udp_tlast),
      .udp_tdata     (udp_tdata),
      .udp_tkeep     (udp_tkeep),
      .m_tvalid      (m_tvalid),
      .m_tlast       (m_tlast),
      .m_tdata       (m_tdata),
      .m_tkeep       (m_tkeep),
      .m_tready      (m_tready),
      .arb_state     (arb_state),
      .arp_frame_cnt (arp_frame_cnt),
      .udp_frame_cnt (udp_frame_cnt)
   );

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] k;
      logic              l;
   } beat_t;

   beat_t qa[$];
   beat_t qu[$];
   int    mr_pat[$];
   int    grant_log[$];
   int    tests = 0;
   int    fails = 0;
   int    pa = 100, pu = 100, pr = 100;
   int    step_no = 0;
   logic  mv_hist [0:15];

   // Model: who owns the stream, burst streak, output register contents, frame totals.
   int    m_owner, m_streak, m_cnt_a, m_cnt_u;
   logic  m_v;
   beat_t m_reg;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_streak = 0;
      m_cnt_a  = 0;
      m_cnt_u  = 0;
      m_v      = 1'b0;
      m_reg    = '0;
   endtask

   task automatic add_frame(input int src, input int nbeats);
      beat_t b;
      for (int i = 0; i < nbeats; i++) begin
         b.d = {$urandom, $urandom};
         b.k = 8'($urandom);
         b.l = (i == nbeats - 1);
         if (src == 0) qa.push_back(b);
         else          qu.push_back(b);
      end
   endtask

   function automatic beat_t junk();
      beat_t b;
      b.d = {$urandom, $urandom};
      b.k = 8'($urandom);
      b.l = 1'($urandom);
      return b;
   endfunction

   // One clock: drive at the falling edge, check settled outputs, then advance the model.
   task automatic step();
      beat_t ha, hu;
      logic  er_a, er_u, acc_a, acc_u;
      ha = (qa.size() > 0) ? qa[0] : junk();
      hu = (qu.size() > 0) ? qu[0] : junk();
      arp_tvalid = (qa.size() > 0) && (int'($urandom_range(99)) < pa);
      udp_tvalid = (qu.size() > 0) && (int'($urandom_range(99)) < pu);
      {arp_tdata, arp_tkeep, arp_tlast} = ha;
      {udp_tdata, udp_tkeep, udp_tlast} = hu;
      if (mr_pat.size() > 0) m_tready = (mr_pat.pop_front() != 0);
      else                   m_tready = (int'($urandom_range(99)) < pr);
      #1;
      er_a = (m_owner == 1) && (!m_v || m_tready);
      er_u = (m_owner == 2) && (!m_v || m_tready);
      chk("arp_tready", 64'(arp_tready), 64'(er_a));
      chk("udp_tready", 64'(udp_tready), 64'(er_u));
      chk("m_tvalid", 64'(m_tvalid), 64'(m_v));
      if (m_v) begin
         chk("m_tdata", m_tdata, m_reg.d);
         chk("m_tkeep", 64'(m_tkeep), 64'(m_reg.k));
         chk("m_tlast", 64'(m_tlast), 64'(m_reg.l));
      end
      chk("arb_state", 64'(arb_state), 64'(m_owner));
      chk("arp_frame_cnt", 64'(arp_frame_cnt), 64'(m_cnt_a));
      chk("udp_frame_cnt", 64'(udp_frame_cnt), 64'(m_cnt_u));
      if (step_no < 16) mv_hist[step_no] = m_tvalid;
      step_no++;

      acc_a = er_a && arp_tvalid;
      acc_u = er_u && udp_tvalid;
      if (rst) begin
         model_reset();
         qa.delete();
         qu.delete();
      end else begin
         if (acc_a) begin
            m_v = 1'b1; m_reg = ha; void'(qa.pop_front());
         end else if (acc_u) begin
            m_v = 1'b1; m_reg = hu; void'(qu.pop_front());
         end else if (m_tready) begin
            m_v = 1'b0;
         end
         if (m_owner == 0) begin
            if (tx_enable && (arp_tvalid || udp_tvalid)) begin
               if (arp_tvalid && (!udp_tvalid || m_streak < BURST)) begin
                  m_owner = 1;
                  if (udp_tvalid) m_streak = (m_streak + 1 > BURST) ? BURST : m_streak + 1;
               end else begin
                  m_owner  = 2;
                  m_streak = 0;
               end
               grant_log.push_back(m_owner);
            end
         end else if (m_owner == 1 && acc_a && ha.l) begin
            m_owner = 0;
            m_cnt_a = (m_cnt_a + 1) % CNT_M;
         end else if (m_owner == 2 && acc_u && hu.l) begin
            m_owner = 0;
            m_cnt_u = (m_cnt_u + 1) % CNT_M;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_until_idle(input int budget, input string name);
      int n = 0;
      while ((qa.size() != 0 || qu.size() != 0 || m_owner != 0 || m_v) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_drained"}, 64'(n < budget), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp1 [7] = '{0, 0, 1, 1, 1, 1, 0};
      int exp2 [6] = '{1, 1, 2, 1, 1, 2};

      rst = 1'b1; tx_enable = 1'b1; m_tready = 1'b0;
      arp_tvalid = 1'b0; arp_tlast = 1'b0; arp_tdata = '0; arp_tkeep = '0;
      udp_tvalid = 1'b0; udp_tlast = 1'b0; udp_tdata = '0; udp_tkeep = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("reset_m_tlast", 64'(m_tlast), 64'd0);
      chk("reset_m_tdata", m_tdata, 64'd0);
      chk("reset_m_tkeep", 64'(m_tkeep), 64'd0);
      chk("reset_state", 64'(arb_state), 64'd0);
      chk("reset_treadys", 64'({arp_tready, udp_tready}), 64'd0);
      chk("reset_cnts", 64'({arp_frame_cnt, udp_frame_cnt}), 64'd0);
      @(negedge clk);

      // Single 4-beat UDP frame with the MAC always ready.
      step_no = 0;
      add_frame(1, 4);
      repeat (5) step();
      chk("t1_tlast_beat4", 64'(m_tlast), 64'd1);
      chk("t1_state_idle", 64'(arb_state), 64'd0);
      chk("t1_udp_cnt", 64'(udp_frame_cnt), 64'd1);
      repeat (2) step();
      for (int i = 0; i < 7; i++) chk($sformatf("t1_valid_c%0d", i), 64'(mv_hist[i]), 64'(exp1[i]));

      // Both sources busy: ARP burst limit forces UDP in every third grant.
      grant_log.delete();
      for (int i = 0; i < 4; i++) add_frame(0, 3);
      for (int i = 0; i < 3; i++) add_frame(1, 3);
      run_until_idle(300, "t2");
      chk("t2_grants", 64'(grant_log.size()), 64'd7);
      for (int i = 0; i < 6; i++)
         chk($sformatf("t2_grant%0d", i), 64'((i < grant_log.size()) ? grant_log[i] : 0), 64'(exp2[i]));
      chk("t2_arp_cnt", 64'(arp_frame_cnt), 64'd4);
      chk("t2_udp_cnt", 64'(udp_frame_cnt), 64'd4);

      // MAC backpressure pattern mid-frame.
      add_frame(1, 6);
      for (int i = 0; i < 4; i++) begin
         mr_pat.push_back(1); mr_pat.push_back(0); mr_pat.push_back(0); mr_pat.push_back(1);
      end
      run_until_idle(100, "t3");
      chk("t3_udp_cnt", 64'(udp_frame_cnt), 64'd5);
      mr_pat.delete();

      // tx_enable drops during an ARP frame with UDP waiting.
      add_frame(0, 5);
      add_frame(1, 2);
      step();
      step();
      tx_enable = 1'b0;
      repeat (14) step();
      chk("t4_arp_done", 64'(arp_frame_cnt), 64'd5);
      chk("t4_no_udp", 64'(udp_frame_cnt), 64'd5);
      chk("t4_idle", 64'(arb_state), 64'd0);
      tx_enable = 1'b1;
      run_until_idle(100, "t4");
      chk("t4_udp_after", 64'(udp_frame_cnt), 64'd6);

      // Reset on beat 3 of a UDP frame.
      add_frame(1, 6);
      repeat (3) step();
      do_reset();
      chk("t5_valid", 64'(m_tvalid), 64'd0);
      chk("t5_state", 64'(arb_state), 64'd0);
      chk("t5_cnts", 64'({arp_frame_cnt, udp_frame_cnt}), 64'd0);
      add_frame(1, 3);
      run_until_idle(100, "t5");
      chk("t5_fresh_cnt", 64'(udp_frame_cnt), 64'd1);

      // Counter wrap with a 4-bit counter.
      for (int i = 0; i < 14; i++) add_frame(1, 1);
      run_until_idle(200, "t6a");
      chk("t6_cnt_max", 64'(udp_frame_cnt), 64'd15);
      add_frame(1, 1);
      run_until_idle(50, "t6b");
      chk("t6_cnt_wrap", 64'(udp_frame_cnt), 64'd0);

      // Randomized traffic, stalls and enable toggling.
      for (int blk = 0; blk < 20; blk++) begin
         pa = 30 + int'($urandom_range(70));
         pu = 30 + int'($urandom_range(70));
         pr = 40 + int'($urandom_range(60));
         for (int c = 0; c < 150; c++) begin
            if (qa.size() < 4 && $urandom_range(3) == 0) add_frame(0, 1 + int'($urandom_range(5)));
            if (qu.size() < 4 && $urandom_range(3) == 0) add_frame(1, 1 + int'($urandom_range(5)));
            tx_enable = ($urandom_range(19) != 0);
            step();
         end
      end
      tx_enable = 1'b1;
      pa = 100; pu = 100; pr = 100;
      run_until_idle(2000, "rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
